// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter.
//   arb_state_t : arbiter FSM states
//   requester_t : which cache owns (or last owned) the pmem port
//   pmem_op_t   : latched downstream operation
package arbiter_types;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } requester_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } pmem_op_t;
endpackage

// File: rtl/pmem_arbiter_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst   : synchronous reset, active low
//   inc   : add one this edge (ignored once the count is all ones)
//   clear : synchronous clear
//   count : current value
module sat_counter #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [width-1:0] count
);
   logic [width-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst || clear)
         r_count <= '0;
      else if (inc && (r_count != {width{1'b1}}))
         r_count <= r_count + 1'b1;
   end

   assign count = r_count;
endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one pmem port between the I-cache and D-cache.
//   i_pmem_*       : I-cache side (read only)
//   d_pmem_*       : D-cache side (read / writeback)
//   pmem_*         : downstream memory port
//   conflict_count : saturating count of IDLE edges with both caches pending
// A grant latches the winner's address/data/op; the downstream port is then
// driven only from those latches until pmem_resp, followed by one RELEASE
// cycle so the requester can drop its request before re-arbitration.
module pmem_arbiter
   import arbiter_types::*;
#(
   parameter int s_line = 256,
   parameter int s_addr = 32,
   parameter int cnt_w  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pmem_read,
   input  logic [s_addr-1:0] i_pmem_address,
   output logic [s_line-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [s_addr-1:0] d_pmem_address,
   input  logic [s_line-1:0] d_pmem_wdata,
   output logic [s_line-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [s_addr-1:0] pmem_address,
   output logic [s_line-1:0] pmem_wdata,
   input  logic [s_line-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic [cnt_w-1:0]  conflict_count
);
   arb_state_t        r_state;
   requester_t        r_last_grant;
   pmem_op_t          r_op;
   logic [s_addr-1:0] r_addr;
   logic [s_line-1:0] r_wdata;

   logic w_pend_i, w_pend_d, w_grant_i, w_grant_d, w_in_grant, w_conflict;

   assign w_pend_i   = i_pmem_read;
   assign w_pend_d   = d_pmem_read | d_pmem_write;
   assign w_conflict = (r_state == IDLE) & w_pend_i & w_pend_d;
   // On a tie the requester that did not win last time goes first.
   assign w_grant_i  = w_pend_i & (~w_pend_d | (r_last_grant == REQ_D));
   assign w_grant_d  = w_pend_d & ~w_grant_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_last_grant <= REQ_D;
         r_op         <= OP_READ;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_i) begin
                  r_state      <= GRANT_I;
                  r_last_grant <= REQ_I;
                  r_addr       <= i_pmem_address;
                  r_wdata      <= '0;
                  r_op         <= OP_READ;
               end else if (w_grant_d) begin
                  r_state      <= GRANT_D;
                  r_last_grant <= REQ_D;
                  r_addr       <= d_pmem_address;
                  r_wdata      <= d_pmem_wdata;
                  // read+write together is a writeback
                  r_op         <= d_pmem_write ? OP_WRITE : OP_READ;
               end
            end
            GRANT_I, GRANT_D: if (pmem_resp) r_state <= RELEASE;
            RELEASE:          r_state <= IDLE;
            default:          r_state <= IDLE;
         endcase
      end
   end

   // Downstream port is a pure decode of state + latches; no input bypass.
   assign w_in_grant   = (r_state == GRANT_I) | (r_state == GRANT_D);
   assign pmem_read    = w_in_grant & (r_op == OP_READ);
   assign pmem_write   = w_in_grant & (r_op == OP_WRITE);
   assign pmem_address = w_in_grant ? r_addr  : '0;
   assign pmem_wdata   = w_in_grant ? r_wdata : '0;

   // Only the completion strobes are steered; read data fans out to both.
   assign i_pmem_resp  = (r_state == GRANT_I) & pmem_resp;
   assign d_pmem_resp  = (r_state == GRANT_D) & pmem_resp;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

   sat_counter #(.width(cnt_w)) u_conflict (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_conflict),
      .clear (1'b0),
      .count (conflict_count)
   );
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_pmem_arbiter;
   localparam int L    = 256;
   localparam int A    = 32;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_read = 1'b0;
   logic [A-1:0]  i_addr = '0;
   logic [L-1:0]  i_rdata;
   logic          i_resp;
   logic          d_read = 1'b0, d_write = 1'b0;
   logic [A-1:0]  d_addr = '0;
   logic [L-1:0]  d_wdata = '0;
   logic [L-1:0]  d_rdata;
   logic          d_resp;
   logic          p_read, p_write;
   logic [A-1:0]  p_addr;
   logic [L-1:0]  p_wdata;
   logic [L-1:0]  p_rdata = '0;
   logic          p_resp = 1'b0;
   logic [CW-1:0] conflict_count;

   always #5 clk = ~clk;

   pmem_arbiter #(.s_line(L), .s_addr(A), .cnt_w(CW)) dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_read), .i_pmem_address(i_addr),
      .i_pmem_rdata(i_rdata), .i_pmem_resp(i_resp),
      .d_pmem_read(d_read), .d_pmem_write(d_write), .d_pmem_address(d_addr),
      .d_pmem_wdata(d_wdata), .d_pmem_rdata(d_rdata), .d_pmem_resp(d_resp),
      .pmem_read(p_read), .pmem_write(p_write), .pmem_address(p_addr),
      .pmem_wdata(p_wdata), .pmem_rdata(p_rdata), .pmem_resp(p_resp),
      .conflict_count(conflict_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // phase 0: waiting for requests, 1: a transaction owns the port,
   // 2: the one quiet cycle after a completion.
   int           m_phase = 0;
   bit           m_valid = 1'b0, m_fresh = 1'b1;
   bit           m_owner, m_last, m_write;   // owner/last: 0 = I, 1 = D
   logic [A-1:0] m_addr;
   logic [L-1:0] m_wdata;
   int           m_cnt = 0;
   int           log_q[$];                   // owners of observed resps

   always @(posedge clk) begin
      bit pi, pd, who;
      pi = i_read;
      pd = d_read | d_write;
      if (!rst) begin
         m_valid <= 1'b1; m_fresh <= 1'b1; m_phase <= 0; m_last <= 1'b1;
         m_cnt <= 0; m_addr <= '0; m_wdata <= '0; m_write <= 1'b0;
      end else if (m_valid) begin
         if (m_phase == 0) begin
            if (pi && pd) m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
            if (pi || pd) begin
               who = (pi && pd) ? !m_last : pd;
               m_owner <= who;
               m_last  <= who;
               m_fresh <= 1'b0;
               m_phase <= 1;
               m_addr  <= who ? d_addr : i_addr;
               m_wdata <= who ? d_wdata : '0;
               m_write <= who & d_write;
            end
         end else if (m_phase == 1) begin
            if (p_resp) m_phase <= 2;
         end else begin
            m_phase <= 0;
         end
      end
   end

   always @(negedge clk) begin
      bit busy;
      if (m_valid) begin
         busy = (m_phase == 1);
         check("pmem_read", p_read, busy && !m_write);
         check("pmem_write", p_write, busy && m_write);
         check("i_pmem_resp", i_resp, busy && !m_owner && p_resp);
         check("d_pmem_resp", d_resp, busy && m_owner && p_resp);
         check("i_pmem_rdata", i_rdata, p_rdata);
         check("d_pmem_rdata", d_rdata, p_rdata);
         check("conflict_count", conflict_count, m_cnt);
         if (busy) check("pmem_address", p_addr, m_addr);
         if (busy && m_write) check("pmem_wdata", p_wdata, m_wdata);
         if (!busy && m_fresh) begin
            check("pmem_address idle", p_addr, 0);
            check("pmem_wdata idle", p_wdata, 0);
         end
         if (i_resp === 1'b1) log_q.push_back(0);
         if (d_resp === 1'b1) log_q.push_back(1);
      end
   end

   // ---------------- downstream memory responder ----------------
   bit          auto_resp = 1'b1, manual_resp = 1'b0, rand_lat = 1'b0, stale_en = 1'b0;
   bit          fixed_en = 1'b0;
   logic [31:0] fixed_word = 32'h0;
   int          cfg_lat = 2;

   initial begin
      int rcnt, lat;
      rcnt = 0;
      lat  = 0;
      forever begin
         @(posedge clk); #1;
         for (int k = 0; k < 8; k++) p_rdata[k*32 +: 32] = fixed_en ? fixed_word : $urandom();
         if (!auto_resp) begin
            rcnt   = 0;
            p_resp = manual_resp;
         end else if (p_resp) begin
            p_resp = 1'b0;
            rcnt   = 0;
         end else if (p_read === 1'b1 || p_write === 1'b1) begin
            if (rcnt == 0) lat = rand_lat ? int'($urandom_range(0, 4)) : cfg_lat;
            rcnt++;
            if (rcnt == lat + 1) p_resp = 1'b1;
         end else begin
            rcnt = 0;
            if (stale_en && $urandom_range(0, 7) == 0) p_resp = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   bit ok;
   int n0;

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // which: 0 = i_resp, 1 = d_resp, 2 = any strobe. Returns at that negedge.
   task automatic wait_for(input int which, output bit found);
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if ((which == 0 && i_resp === 1'b1) || (which == 1 && d_resp === 1'b1) ||
             (which == 2 && (p_read === 1'b1 || p_write === 1'b1))) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_for(%0d): timeout, got no event want event", which);
      end
   endtask

   function automatic logic [L-1:0] rand_line();
      logic [L-1:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   initial begin
      // reset state
      do_reset();
      @(negedge clk);
      check("rst conflict_count", conflict_count, 0);
      check("rst pmem_read", p_read, 0);
      check("rst pmem_address", p_addr, 0);

      // I-only read, resp 5 cycles after the strobe, fixed line data
      cfg_lat = 5; fixed_en = 1'b1; fixed_word = 32'hDEADBEEF;
      @(posedge clk); #1; i_read = 1'b1; i_addr = 32'h60;
      @(posedge clk); @(negedge clk);
      check("t1 strobe", p_read, 1);
      check("t1 addr", p_addr, 32'h60);
      n0 = log_q.size();
      wait_for(0, ok);
      if (ok) begin
         check("t1 rdata", i_rdata, {8{32'hDEADBEEF}});
         check("t1 d_resp", d_resp, 0);
      end
      @(posedge clk); #1; i_read = 1'b0;
      @(negedge clk);
      check("t1 release strobe", p_read, 0);
      repeat (3) @(negedge clk);
      check("t1 resp pulses", log_q.size() - n0, 1);
      fixed_en = 1'b0;

      // simultaneous I read / D write after reset: I first, then D
      do_reset();
      cfg_lat = 2;
      @(posedge clk); #1;
      i_read = 1'b1; i_addr = 32'h100;
      d_write = 1'b1; d_addr = 32'h200; d_wdata = {8{32'hA5A5A5A5}};
      wait_for(2, ok);
      check("t2 first is I read", p_read, 1);
      check("t2 first addr", p_addr, 32'h100);
      wait_for(0, ok);
      @(posedge clk); #1; i_read = 1'b0;
      wait_for(2, ok);
      check("t2 D write", p_write, 1);
      check("t2 D addr", p_addr, 32'h200);
      check("t2 D wdata", p_wdata, {8{32'hA5A5A5A5}});
      wait_for(1, ok);
      @(posedge clk); #1; d_write = 1'b0;
      @(negedge clk);
      check("t2 conflict_count", conflict_count, 1);

      // continuous contention: strict alternation I, D, I, D
      do_reset();
      @(posedge clk); #1;
      i_read = 1'b1; i_addr = 32'h400; d_read = 1'b1; d_addr = 32'h500;
      n0 = log_q.size();
      for (int c = 0; c < 200 && (log_q.size() - n0) < 4; c++) @(negedge clk);
      @(posedge clk); #1; i_read = 1'b0; d_read = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (log_q.size() > n0 + k) check("t3 grant order", log_q[n0+k], k % 2);
         else check("t3 resp count", log_q.size() - n0, 4);
      end

      // D read+write together is a write
      do_reset();
      @(posedge clk); #1; d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wdata = rand_line();
      wait_for(2, ok);
      check("t4 pmem_write", p_write, 1);
      check("t4 pmem_read", p_read, 0);
      check("t4 addr", p_addr, 32'h300);
      wait_for(1, ok);
      @(posedge clk); #1; d_read = 1'b0; d_write = 1'b0;

      // reset during GRANT_D, then a stale resp
      do_reset();
      auto_resp = 1'b0; manual_resp = 1'b0;
      @(posedge clk); #1; d_write = 1'b1; d_addr = 32'h700; d_wdata = rand_line();
      wait_for(2, ok);
      @(posedge clk); #1; rst = 1'b0; d_write = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      check("t5 write after reset", p_write, 0);
      check("t5 read after reset", p_read, 0);
      manual_resp = 1'b1;
      @(negedge clk);
      check("t5 stale d_resp", d_resp, 0);
      check("t5 stale i_resp", i_resp, 0);
      manual_resp = 1'b0;
      @(negedge clk);
      auto_resp = 1'b1;
      @(posedge clk); #1; i_read = 1'b1; i_addr = 32'h80;
      @(posedge clk); @(negedge clk);
      check("t5 idle regrant", p_read, 1);
      check("t5 regrant addr", p_addr, 32'h80);
      wait_for(0, ok);
      @(posedge clk); #1; i_read = 1'b0;

      // counter saturation over 20 contended arbitrations
      do_reset();
      cfg_lat = 0;
      @(posedge clk); #1; i_read = 1'b1; d_read = 1'b1;
      n0 = log_q.size();
      for (int c = 0; c < 300 && (log_q.size() - n0) < 20; c++) @(negedge clk);
      @(posedge clk); #1; i_read = 1'b0; d_read = 1'b0;
      @(negedge clk);
      check("t6 saturated count", conflict_count, 15);

      // randomized traffic with drops, stale resps and occasional resets
      do_reset();
      rand_lat = 1'b1; stale_en = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         bit si, sd;
         @(negedge clk); si = i_resp; sd = d_resp;
         @(posedge clk); #1;
         if (i_read) begin
            if (si || $urandom_range(0, 15) == 0) i_read = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            i_read = 1'b1; i_addr = $urandom();
         end
         if (d_read || d_write) begin
            if (sd || $urandom_range(0, 15) == 0) begin d_read = 1'b0; d_write = 1'b0; end
         end else if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
               0:       begin d_read = 1'b1; d_write = 1'b0; end
               1:       begin d_read = 1'b0; d_write = 1'b1; end
               default: begin d_read = 1'b1; d_write = 1'b1; end
            endcase
            d_addr = $urandom(); d_wdata = rand_line();
         end
         rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; stale_en = 1'b0;
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache.
- Both requesters present 256-bit line transactions.
- The arbiter grants one requester at a time using round-robin and forwards the transaction to the downstream pmem port.
- It routes the response back to the granted requester and keeps a saturating conflict counter for performance analysis.

Parameters:
- s_line, 256, line width in bits.
- s_addr, 32, address width.
- cnt_w, 16, width of the conflict counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- i_pmem_read  in  1  I-cache line read request (the I-cache never writes)
- i_pmem_address  in  s_addr  I-cache line address
- i_pmem_rdata  out  s_line  read data to I-cache
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache line write request (writeback)
- d_pmem_address  in  s_addr  D-cache line address
- d_pmem_wdata  in  s_line  D-cache writeback data
- d_pmem_rdata  out  s_line  read data to D-cache
- d_pmem_resp  out  1  D-cache transaction complete
- pmem_read  out  1  downstream read strobe
- pmem_write  out  1  downstream write strobe
- pmem_address  out  s_addr  downstream address
- pmem_wdata  out  s_line  downstream write data
- pmem_rdata  in  s_line  downstream read data
- pmem_resp  in  1  downstream completion
- conflict_count  out  cnt_w  cycles in IDLE with both requests pending, saturating

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous and active-low.
  - At the first posedge with rst==0: state=IDLE, last_grant=D, conflict_count=0, latched address/wdata/op cleared.
- Output reset values:
  - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0 from that edge onward.
  - pmem_address and pmem_wdata are 0 from that edge onward.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - pending_i = i_pmem_read; pending_d = d_pmem_read | d_pmem_write.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant.
  - On the grant edge, latch the requester's address, wdata and op, update last_grant, and move to GRANT_x.
- Request latency: request sampled at edge N; pmem strobe asserted from the cycle after edge N (one-cycle latency).
- GRANT_x:
  - pmem_read / pmem_write / pmem_address / pmem_wdata are driven from the latched registers only; combinational decode of state, no input pass-through.
  - The strobe is held until pmem_resp==1.
  - In the pmem_resp cycle, x_pmem_resp = 1 combinationally and x_pmem_rdata = pmem_rdata. The other requester's resp stays 0.
  - Next state is RELEASE.
- RELEASE:
  - Exactly one cycle with all strobes low.
  - This lets the requester drop its request before re-arbitration.
  - Next state is IDLE.
- Both D ops asserted: d_pmem_read and d_pmem_write together is treated as a write.
- Request dropped mid-grant: the transaction still runs to pmem_resp.
- Response outside a grant: pmem_resp in IDLE or RELEASE is ignored and no requester resp is generated.
- rdata fan-out: i_pmem_rdata and d_pmem_rdata both equal pmem_rdata at all times. Only the resp signals are steered.
- conflict_count:
  - Increments by 1 on each edge where state==IDLE and both requests are pending.
  - Saturates at 2^cnt_w − 1.
- Reset mid-transaction:
  - Abandons the transaction; strobes drop from the reset edge.
  - A later stale pmem_resp is ignored.
- Fairness: with both requesters held continuously, grants strictly alternate, giving worst-case wait of one transaction plus 2 cycles.

Decomposition:
- Package arbiter_types holds:
  - enum arb_state_t {IDLE, GRANT_I, GRANT_D, RELEASE}
  - enum requester_t {REQ_I, REQ_D}
  - enum pmem_op_t {OP_READ, OP_WRITE}
- One natural sub-module, sat_counter: parameter width, inputs inc and clear, output count, synchronous active-low reset. It implements conflict_count.
- The FSM, latches and muxes stay in pmem_arbiter.

Test Plan:
- I-only read: I read at 0x00000060, pmem_resp 5 cycles after the strobe, rdata = {8{32'hDEADBEEF}}.
  - pmem_read=1 and pmem_address=0x60 from the cycle after the request.
  - i_pmem_resp=1 for exactly 1 cycle with matching rdata; d_pmem_resp stays 0.
  - One RELEASE cycle follows.
- Simultaneous after reset: I read 0x100 and D write 0x200 (wdata = {8{32'hA5A5A5A5}}) in the same cycle.
  - I is served first.
  - Then D: pmem_write=1, address 0x200, wdata matching.
  - conflict_count = 1.
- Continuous contention: both held asserted for 4 transactions, resp latency 2.
  - Grant order is I, D, I, D.
  - Each resp goes only to its owner; a RELEASE cycle sits between every pair.
- D read and write together at 0x300: pmem_write=1, pmem_read=0.
- Reset mid-grant: rst=0 for 1 cycle during GRANT_D, then pmem_resp pulses 2 cycles later.
  - Strobes are 0 from the reset edge.
  - No d_pmem_resp; state is IDLE.
- Counter saturation: cnt_w=4, both requests held pending through 20 arbitration points; conflict_count saturates at 15 and does not wrap.
